// File: rtl/piso_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the parallel-in, serial-out
//               transmitter. Holds the two-state FSM enumeration and the
//               function that sizes the bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Transmitter FSM states. IDLE waits for a word; SHIFT is sending one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the bit counter for a WIDTH-bit word. The counter only has to
  // reach WIDTH-1, and it is never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serial_tx_if
// Description : Load handshake and serial output bundle of the PISO
//               transmitter.
//   din        - parallel word offered for transmission
//   load_valid - a word is offered on din
//   load_ready - the transmitter can take a word this cycle
//   sout       - serial data bit
//   sout_valid - sout carries a valid bit this cycle
//   busy       - a word is in flight
//   done       - pulse during the last bit of a word
// Modports    : master - word producer / serial consumer side
//               slave  - the transmitter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );

endinterface : piso_serial_tx_if
`default_nettype wire

// File: rtl/piso_serial_tx_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux_2x1
// Description : Single-bit two-input multiplexer. One instance sits in front
//               of each shift-register bit and chooses between the parallel
//               load bit and the neighbouring bit being shifted in.
// Ports       : a_i   - input selected when sel_i = 0 (shift path)
//               b_i   - input selected when sel_i = 1 (load path)
//               sel_i - select
//               y_o   - selected value
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2x1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule : mux_2x1
`default_nettype wire

// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_serial_tx
// Description : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word
//               over a valid/ready load handshake and sends it one bit per
//               clock with a qualifying valid strobe. A new word may be taken
//               during the last bit of the current one, giving a gapless
//               stream when words are offered continuously.
// Parameters  : WIDTH     - word width in bits (2..32)
//               LSB_FIRST - 1: bit 0 is sent first; 0: bit WIDTH-1 first
// Ports       : clk   - clock, rising edge active
//               rst_n - asynchronous active-low reset
//               tx_if - load handshake and serial output bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_serial_tx_if.slave  tx_if
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam int                OUT_IDX  = LSB_FIRST ? 0 : WIDTH - 1;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  logic [WIDTH-1:0] w_shift;
  logic             w_busy;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_sr_en;

  // --------------------------------------------------------------------------
  // Handshake decode: everything here depends only on state and counter, so
  // load_ready never has a combinational path from load_valid.
  // --------------------------------------------------------------------------
  assign w_busy   = (state_q == ST_SHIFT);
  assign w_last   = w_busy && (cnt_q == CNT_LAST);
  assign w_ready  = (state_q == ST_IDLE) || w_last;
  assign w_accept = tx_if.load_valid && w_ready;

  // The register only moves while a word is in flight or being loaded, so it
  // holds its all-zero content while idle.
  assign w_sr_en  = w_accept || w_busy;

  // --------------------------------------------------------------------------
  // Shift register datapath: each bit picks either its din bit (on accept) or
  // its upstream neighbour, with zero entering at the far end.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (LSB_FIRST) begin : g_lsb
        // Bits move toward bit 0, which is the output end.
        if (i == WIDTH - 1) begin : g_fill
          assign w_shift[i] = 1'b0;
        end else begin : g_move
          assign w_shift[i] = sr_q[i+1];
        end
      end else begin : g_msb
        // Bits move toward bit WIDTH-1, which is the output end.
        if (i == 0) begin : g_fill
          assign w_shift[i] = 1'b0;
        end else begin : g_move
          assign w_shift[i] = sr_q[i-1];
        end
      end

      mux_2x1 u_mux (
        .a_i   (w_shift[i]),
        .b_i   (tx_if.din[i]),
        .sel_i (w_accept),
        .y_o   (sr_d[i])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM and bit counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          // Either restart on a back-to-back word or fall back to idle; the
          // counter returns to zero in both cases and never wraps.
          cnt_d   = '0;
          state_d = tx_if.load_valid ? ST_SHIFT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_sr_en) begin
        sr_q <= sr_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  assign tx_if.load_ready = w_ready;
  assign tx_if.sout_valid = w_busy;
  assign tx_if.busy       = w_busy;
  assign tx_if.done       = w_last;
  // Forced low while idle so the line never shows stale register content.
  assign tx_if.sout       = w_busy & sr_q[OUT_IDX];

endmodule : piso_serial_tx
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serial_tx
// Description : Self-checking bench for piso_serial_tx. Two instances (LSB
//               first and MSB first) receive the same load stimulus. A
//               reference model turns every accepted word into a list of
//               expected (bit, done) pairs; monitors pop and compare them
//               whenever an instance presents a valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serial_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  piso_serial_tx_if #(.WIDTH(W)) if_l ();
  piso_serial_tx_if #(.WIDTH(W)) if_m ();

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (if_l.slave)
  );

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (if_m.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: rem counts bits of the current word still to be shown.
  // A word is taken when the line is empty or showing its final bit.
  // --------------------------------------------------------------------------
  int         rem = 0;
  logic [1:0] ql[$];   // {bit, done} expected from the LSB-first instance
  logic [1:0] qm[$];   // {bit, done} expected from the MSB-first instance

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0;
      ql.delete();
      qm.delete();
    end else begin
      bit         can_take;
      logic [W-1:0] word;
      can_take = (rem <= 1);
      word     = if_l.din;
      if (rem > 0) rem--;
      if (if_l.load_valid && can_take) begin
        rem = W;
        for (int k = 0; k < W; k++) begin
          ql.push_back({word[k],       1'(k == W - 1)});
          qm.push_back({word[W-1-k],   1'(k == W - 1)});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitors, sampling on the falling edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [1:0] e;
    chk("L sout_valid", {31'b0, if_l.sout_valid}, {31'b0, 1'(rem > 0)});
    chk("L busy",       {31'b0, if_l.busy},       {31'b0, 1'(rem > 0)});
    chk("L load_ready", {31'b0, if_l.load_ready}, {31'b0, 1'(rem <= 1)});
    if (if_l.sout_valid) begin
      chk("L expected bit pending", {31'b0, 1'(ql.size() > 0)}, 32'd1);
      if (ql.size() > 0) begin
        e = ql.pop_front();
        chk("L sout", {31'b0, if_l.sout}, {31'b0, e[1]});
        chk("L done", {31'b0, if_l.done}, {31'b0, e[0]});
      end
    end else begin
      chk("L sout idle", {31'b0, if_l.sout}, 32'd0);
      chk("L done idle", {31'b0, if_l.done}, 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    chk("M sout_valid", {31'b0, if_m.sout_valid}, {31'b0, 1'(rem > 0)});
    chk("M busy",       {31'b0, if_m.busy},       {31'b0, 1'(rem > 0)});
    chk("M load_ready", {31'b0, if_m.load_ready}, {31'b0, 1'(rem <= 1)});
    if (if_m.sout_valid) begin
      chk("M expected bit pending", {31'b0, 1'(qm.size() > 0)}, 32'd1);
      if (qm.size() > 0) begin
        e = qm.pop_front();
        chk("M sout", {31'b0, if_m.sout}, {31'b0, e[1]});
        chk("M done", {31'b0, if_m.done}, {31'b0, e[0]});
      end
    end else begin
      chk("M sout idle", {31'b0, if_m.sout}, 32'd0);
      chk("M done idle", {31'b0, if_m.done}, 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] d);
    if_l.load_valid = lv;
    if_m.load_valid = lv;
    if_l.din        = d;
    if_m.din        = d;
  endtask

  task automatic send_one(input logic [W-1:0] d);
    drive(1'b1, d);
    tick();
    drive(1'b0, W'($urandom));
    repeat (W + 4) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " L sout_valid"}, {31'b0, if_l.sout_valid}, 32'd0);
    chk({tag, " L busy"},       {31'b0, if_l.busy},       32'd0);
    chk({tag, " L done"},       {31'b0, if_l.done},       32'd0);
    chk({tag, " L sout"},       {31'b0, if_l.sout},       32'd0);
    chk({tag, " L load_ready"}, {31'b0, if_l.load_ready}, 32'd1);
    chk({tag, " M sout_valid"}, {31'b0, if_m.sout_valid}, 32'd0);
    chk({tag, " M busy"},       {31'b0, if_m.busy},       32'd0);
    chk({tag, " M load_ready"}, {31'b0, if_m.load_ready}, 32'd1);
  endtask

  initial begin
    drive(1'b0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in reset");
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("after reset");

    // Single words, one-cycle load pulse each.
    send_one(8'hA5);
    send_one(8'hC3);

    // Back-to-back: din changes while the first word is in flight must be
    // ignored; 8'hFF is offered at the first word's last bit.
    drive(1'b1, 8'h01);
    tick();
    for (int k = 0; k < W - 1; k++) begin
      drive(1'b1, W'($urandom));
      tick();
    end
    drive(1'b1, 8'hFF);
    tick();
    drive(1'b0, W'($urandom));
    repeat (W + 4) tick();

    // Reset mid-word, asserted between edges after the third bit.
    drive(1'b1, 8'h5A);
    tick();
    drive(1'b0, '0);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid-word reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_one(8'h0F);

    // Randomised load traffic, including long back-to-back runs.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom));
      tick();
    end
    drive(1'b0, '0);
    repeat (W + 4) tick();

    chk("L queue drained", ql.size(), 32'd0);
    chk("M queue drained", qm.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_piso_serial_tx
`default_nettype wire

// File: doc/piso_serial_tx.md
# piso_serial_tx

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock with a qualifying valid strobe. It is the send end of the single-bit data-plus-control links used by our latch and flop storage blocks. Its mux-selected load/shift register is the write-side counterpart to the mux-based storage elements already in the design.

## Interface
Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately; release is synchronous to clk.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  a word is offered on din.
- load_ready  output  1  the block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse, high during the last bit of a word.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, busy=0, sout=0.
  - Accept when load_valid && load_ready at a rising edge: capture din into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - sout_valid=1, busy=1.
  - sout is the current output bit of the shift register: bit 0 if LSB_FIRST=1, else bit WIDTH-1.
  - Each edge shifts the register one position toward the output end, fills with 0, and increments the counter.
- Last bit (counter == WIDTH-1):
  - done=1 and load_ready=1.
  - If load_valid is high at that edge: load the new word and restart the counter at 0, staying in SHIFT. This is back-to-back operation with no idle gap.
  - Otherwise: go to IDLE.
- Outside the last-bit cycle, load_ready=0 in SHIFT. load_valid is ignored and din is not sampled.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.
- Each word is sent exactly once.
- load_valid held high continuously produces a gapless stream in which every word occupies exactly WIDTH cycles.
- Reset mid-word:
  - The word is abandoned; no partial completion.
  - All outputs take their reset values immediately.
  - The shift register and counter clear to 0.

## Timing
- Reset values: load_ready=1, sout=0, sout_valid=0, busy=0, done=0; state IDLE.
- Latency: the first bit appears on sout with sout_valid=1 in the cycle immediately after the accepting edge (one clock).
- A word occupies exactly WIDTH consecutive sout_valid cycles.
- done is high only in the WIDTH-th cycle of each word.
- Throughput: one word per WIDTH cycles in back-to-back mode. In non-back-to-back mode, WIDTH+1 cycles minimum (one IDLE cycle).
- Output drive:
  - All outputs are registered or decoded only from state and counter.
  - load_ready does not depend combinationally on load_valid.

## Structure
- Shared package piso_pkg holds:
  - the state enum {IDLE, SHIFT};
  - a localparam function returning the counter width ($clog2 with a minimum of 1).
- Sub-module: one mux_2x1 per shift-register bit, selecting load (din bit) versus shift (neighbour bit). The select is the accept strobe.
- The top level holds the FSM, the counter and the output decode.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> load_ready=1, sout_valid=0, busy=0, done=0. Assert rst_n=0 between edges -> outputs clear before the next edge.
- Single word, WIDTH=8, LSB_FIRST=1, din=8'hA5, load_valid pulsed for 1 cycle -> sout=1,0,1,0,0,1,0,1 on 8 consecutive sout_valid cycles starting the cycle after acceptance. done=1 on the 8th; then IDLE.
- MSB first, LSB_FIRST=0, din=8'hC3 -> sout=1,1,0,0,0,0,1,1. busy is high for exactly 8 cycles.
- Back-to-back: load_valid held high with din=8'h01 then 8'hFF -> 16 consecutive sout_valid cycles with no gap. The second word is captured at the first word's done edge. Changing din mid-word has no effect.
- Reset mid-word: assert rst_n=0 after the 3rd bit of 8'h5A -> sout_valid=0 immediately. After release, din=8'h0F transmits cleanly with no residue from 8'h5A.
